// File: rtl/keypoint_scan_ctrl.sv
// Row-sequencing controller for the DoG keypoint stage: walks the scale-space SRAMs row by row,
// serialises per-channel candidate flags through external filters and stores passing keypoints.
module keypoint_scan_ctrl #(
    parameter int NCH      = 2,
    parameter int COLS     = 640,
    parameter int ROWS     = 480,
    parameter int RAW      = 9,
    parameter int CAW      = 10,
    parameter int KAW      = 11,
    parameter int SRAM_LAT = 2
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_start,
    input  logic                      i_abort,
    output logic                      o_done,
    output logic                      o_busy,
    output logic [RAW-1:0]            o_row_addr,
    output logic                      o_buffer_we,
    input  logic [NCH*COLS-1:0]       i_cand_flags,
    output logic [NCH-1:0]            o_cand_vld,
    output logic [NCH*CAW-1:0]        o_cand_col,
    input  logic [NCH-1:0]            i_filt_pass,
    output logic [NCH-1:0]            o_kp_we,
    output logic [NCH*KAW-1:0]        o_kp_addr,
    output logic [NCH*(RAW+CAW)-1:0]  o_kp_din,
    output logic [NCH*(KAW+1)-1:0]    o_kp_count,
    output logic [NCH-1:0]            o_kp_overflow,
    output logic [2:0]                o_dbg_state
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FETCH   = 3'd1;
    localparam logic [2:0] S_SCAN    = 3'd2;
    localparam logic [2:0] S_ADVANCE = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    localparam int             LW       = (SRAM_LAT > 1) ? $clog2(SRAM_LAT) : 1;
    localparam logic [LW-1:0]  LAT_LAST = LW'(SRAM_LAT - 1);
    localparam logic [KAW-1:0] ADDR_MAX = '1;
    localparam logic [KAW:0]   CNT_ONE  = (KAW+1)'(1);
    localparam logic [RAW-1:0] ROW_LAST = RAW'(ROWS - 1);

    logic [2:0]                      r_state;
    logic [RAW-1:0]                  r_row_addr;
    logic [LW-1:0]                   r_lat;
    logic [NCH-1:0][COLS-1:0]        r_mask;
    logic [NCH-1:0][KAW-1:0]         r_kp_addr;
    logic [NCH-1:0][RAW+CAW-1:0]     r_kp_din;
    logic [NCH-1:0][KAW:0]           r_kp_count;
    logic [NCH-1:0]                  r_kp_we;
    logic [NCH-1:0]                  r_kp_full;
    logic [NCH-1:0]                  r_kp_overflow;

    logic [NCH-1:0][COLS-1:0]        w_flags;
    logic [NCH-1:0][COLS-1:0]        w_mask_next;
    logic [NCH-1:0][CAW-1:0]         w_col;
    logic [NCH-1:0]                  w_vld;
    logic [NCH-1:0]                  w_pass;
    logic [NCH-1:0]                  w_full_eff;
    logic                            w_fetch_done;
    logic                            w_latch;
    logic                            w_scan_last;
    logic                            w_start_frame;
    logic [RAW-1:0]                  w_center_row;

    always_comb begin
        w_fetch_done  = (r_state == S_FETCH) && (r_lat == LAT_LAST);
        w_latch       = w_fetch_done && (r_row_addr >= RAW'(2)) && !i_abort;
        w_start_frame = (r_state == S_IDLE) && i_start && !i_abort;
        w_center_row  = r_row_addr - RAW'(1);
        w_scan_last   = 1'b1;
        for (int ch = 0; ch < NCH; ch++) begin
            // Border columns have no full 3x3 neighbourhood, so they are never reported.
            w_flags[ch]           = i_cand_flags[ch*COLS +: COLS];
            w_flags[ch][0]        = 1'b0;
            w_flags[ch][COLS-1]   = 1'b0;
            w_mask_next[ch]       = r_mask[ch] & (r_mask[ch] - COLS'(1));
            w_vld[ch]             = (r_state == S_SCAN) && (r_mask[ch] != '0);
            w_col[ch]             = '0;
            for (int c = COLS - 1; c >= 0; c--) begin
                if (r_mask[ch][c]) begin
                    w_col[ch] = CAW'(c);
                end
            end
            w_pass[ch]     = w_vld[ch] && i_filt_pass[ch] && !i_abort;
            // A write in flight at the last address makes the channel full for this cycle's pass.
            w_full_eff[ch] = r_kp_full[ch] || (r_kp_we[ch] && (r_kp_addr[ch] == ADDR_MAX));
            if (w_mask_next[ch] != '0) begin
                w_scan_last = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_row_addr <= '0;
            r_lat      <= '0;
        end else if (i_abort) begin
            r_state <= S_IDLE;
            r_lat   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state    <= S_FETCH;
                        r_row_addr <= '0;
                        r_lat      <= '0;
                    end
                end
                S_FETCH: begin
                    if (w_fetch_done) begin
                        r_lat   <= '0;
                        r_state <= (r_row_addr >= RAW'(2)) ? S_SCAN : S_ADVANCE;
                    end else begin
                        r_lat <= r_lat + LW'(1);
                    end
                end
                S_SCAN: begin
                    if (w_scan_last) begin
                        r_state <= S_ADVANCE;
                    end
                end
                S_ADVANCE: begin
                    if (r_row_addr == ROW_LAST) begin
                        r_state <= S_DONE;
                    end else begin
                        r_row_addr <= r_row_addr + RAW'(1);
                        r_state    <= S_FETCH;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        for (int ch = 0; ch < NCH; ch++) begin
            if (!i_rst_n || i_abort) begin
                r_mask[ch] <= '0;
            end else if (w_latch) begin
                r_mask[ch] <= w_flags[ch];
            end else if (r_state == S_SCAN) begin
                r_mask[ch] <= w_mask_next[ch];
            end
        end
    end

    // Write path: a pass sampled this cycle becomes a registered SRAM write next cycle;
    // the address/count advance when that write retires.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || w_start_frame) begin
            r_kp_addr     <= '0;
            r_kp_din      <= '0;
            r_kp_count    <= '0;
            r_kp_we       <= '0;
            r_kp_full     <= '0;
            r_kp_overflow <= '0;
        end else begin
            for (int ch = 0; ch < NCH; ch++) begin
                r_kp_we[ch] <= 1'b0;
                if (r_kp_we[ch]) begin
                    r_kp_count[ch] <= r_kp_count[ch] + CNT_ONE;
                    if (r_kp_addr[ch] == ADDR_MAX) begin
                        r_kp_full[ch] <= 1'b1;
                    end else begin
                        r_kp_addr[ch] <= r_kp_addr[ch] + KAW'(1);
                    end
                end
                if (w_pass[ch]) begin
                    if (w_full_eff[ch]) begin
                        r_kp_overflow[ch] <= 1'b1;
                    end else begin
                        r_kp_we[ch]  <= 1'b1;
                        r_kp_din[ch] <= {w_center_row, w_col[ch]};
                    end
                end
            end
        end
    end

    always_comb begin
        o_done        = (r_state == S_DONE);
        o_busy        = (r_state != S_IDLE);
        o_buffer_we   = (r_state == S_ADVANCE);
        o_row_addr    = r_row_addr;
        o_dbg_state   = r_state;
        o_cand_vld    = w_vld;
        o_kp_we       = r_kp_we;
        o_kp_overflow = r_kp_overflow;
        o_cand_col    = '0;
        o_kp_addr     = '0;
        o_kp_din      = '0;
        o_kp_count    = '0;
        for (int ch = 0; ch < NCH; ch++) begin
            o_cand_col[ch*CAW +: CAW]           = w_vld[ch] ? w_col[ch] : '0;
            o_kp_addr[ch*KAW +: KAW]            = r_kp_addr[ch];
            o_kp_din[ch*(RAW+CAW) +: (RAW+CAW)] = r_kp_din[ch];
            o_kp_count[ch*(KAW+1) +: (KAW+1)]   = r_kp_count[ch];
        end
    end

endmodule

// File: tb/tb_keypoint_scan_ctrl.sv
// Bench for keypoint_scan_ctrl: table of frame scenarios checked against a write-stream
// scoreboard, plus hand-written abort / start-hold / priority sequences.
module tb_keypoint_scan_ctrl;
    localparam int NCH      = 2;
    localparam int COLS     = 16;
    localparam int ROWS     = 6;
    localparam int RAW      = 9;
    localparam int CAW      = 10;
    localparam int KAW      = 3;
    localparam int SRAM_LAT = 2;
    localparam int DW       = RAW + CAW;
    localparam int W        = KAW + DW;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     start = 1'b0;
    logic                     abort = 1'b0;
    logic                     done;
    logic                     busy;
    logic [RAW-1:0]           row_addr;
    logic                     buffer_we;
    logic [NCH*COLS-1:0]      cand_flags;
    logic [NCH-1:0]           cand_vld;
    logic [NCH*CAW-1:0]       cand_col;
    logic [NCH-1:0]           filt_pass;
    logic [NCH-1:0]           kp_we;
    logic [NCH*KAW-1:0]       kp_addr;
    logic [NCH*DW-1:0]        kp_din;
    logic [NCH*(KAW+1)-1:0]   kp_count;
    logic [NCH-1:0]           kp_overflow;
    logic [2:0]               dbg_state;

    keypoint_scan_ctrl #(
        .NCH(NCH), .COLS(COLS), .ROWS(ROWS), .RAW(RAW),
        .CAW(CAW), .KAW(KAW), .SRAM_LAT(SRAM_LAT)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort),
        .o_done(done), .o_busy(busy), .o_row_addr(row_addr), .o_buffer_we(buffer_we),
        .i_cand_flags(cand_flags), .o_cand_vld(cand_vld), .o_cand_col(cand_col),
        .i_filt_pass(filt_pass), .o_kp_we(kp_we), .o_kp_addr(kp_addr), .o_kp_din(kp_din),
        .o_kp_count(kp_count), .o_kp_overflow(kp_overflow), .o_dbg_state(dbg_state)
    );

    // ---------------- clock / reset
    always #5 clk = ~clk;

    // ---------------- scenario storage and environment models (SRAM rows, filter)
    typedef struct {
        string                     name;
        logic [ROWS-1:0][COLS-1:0] f0;
        logic [ROWS-1:0][COLS-1:0] f1;
        logic [COLS-1:0]           rej0;
        logic [COLS-1:0]           rej1;
        int                        exp_cnt0;
        int                        exp_cnt1;
        logic                      exp_ovf0;
        logic                      exp_ovf1;
        int                        exp_done;
    } vec_t;

    vec_t vecs[5];

    logic [ROWS-1:0][COLS-1:0] cur_f0;
    logic [ROWS-1:0][COLS-1:0] cur_f1;
    logic [COLS-1:0]           cur_rej0;
    logic [COLS-1:0]           cur_rej1;

    always_comb begin
        cand_flags = '0;
        if (int'(row_addr) < ROWS) begin
            cand_flags = {cur_f1[int'(row_addr)], cur_f0[int'(row_addr)]};
        end
    end

    always_comb begin
        filt_pass[0] = ~cur_rej0[cand_col[3:0]];
        filt_pass[1] = ~cur_rej1[cand_col[CAW+3:CAW]];
    end

    // ---------------- scoreboard
    int errors = 0;
    int checks = 0;

    logic [W-1:0] exp_q0[$];
    logic [W-1:0] exp_q1[$];
    logic [W-1:0] e0;
    logic [W-1:0] e1;
    int  bw_cnt, done_cnt, vld_cnt0, vld_cnt1, wr_cnt0, wr_cnt1;
    int  mdl_vld0, mdl_vld1, mdl_cnt0, mdl_cnt1;
    logic mdl_ovf0, mdl_ovf1;
    bit  mon_en = 1'b0;
    bit  sb_en  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic build_model();
        exp_q0.delete();
        exp_q1.delete();
        mdl_vld0 = 0; mdl_vld1 = 0; mdl_cnt0 = 0; mdl_cnt1 = 0;
        mdl_ovf0 = 1'b0; mdl_ovf1 = 1'b0;
        for (int r = 2; r < ROWS; r++) begin
            for (int c = 1; c < COLS - 1; c++) begin
                if (cur_f0[r][c]) begin
                    mdl_vld0++;
                    if (!cur_rej0[c]) begin
                        if (mdl_cnt0 < (1 << KAW)) begin
                            exp_q0.push_back({KAW'(mdl_cnt0), RAW'(r - 1), CAW'(c)});
                            mdl_cnt0++;
                        end else mdl_ovf0 = 1'b1;
                    end
                end
                if (cur_f1[r][c]) begin
                    mdl_vld1++;
                    if (!cur_rej1[c]) begin
                        if (mdl_cnt1 < (1 << KAW)) begin
                            exp_q1.push_back({KAW'(mdl_cnt1), RAW'(r - 1), CAW'(c)});
                            mdl_cnt1++;
                        end else mdl_ovf1 = 1'b1;
                    end
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (buffer_we) begin
                check("row_addr_at_buffer_we", 32'(row_addr), 32'(bw_cnt));
                bw_cnt++;
            end
            if (done) done_cnt++;
            if (cand_vld[0]) vld_cnt0++;
            if (cand_vld[1]) vld_cnt1++;
            if (kp_we[0]) begin
                wr_cnt0++;
                if (sb_en) begin
                    if (exp_q0.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL ch0_write: actual=%0h expected=none", {kp_addr[KAW-1:0], kp_din[DW-1:0]});
                    end else begin
                        e0 = exp_q0.pop_front();
                        check("ch0_write", 32'({kp_addr[KAW-1:0], kp_din[DW-1:0]}), 32'(e0));
                    end
                end
            end
            if (kp_we[1]) begin
                wr_cnt1++;
                if (sb_en) begin
                    if (exp_q1.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL ch1_write: actual=%0h expected=none", {kp_addr[2*KAW-1:KAW], kp_din[2*DW-1:DW]});
                    end else begin
                        e1 = exp_q1.pop_front();
                        check("ch1_write", 32'({kp_addr[2*KAW-1:KAW], kp_din[2*DW-1:DW]}), 32'(e1));
                    end
                end
            end
        end
    end

    // ---------------- driver tasks
    task automatic start_frame();
        @(negedge clk);
        bw_cnt = 0; done_cnt = 0; vld_cnt0 = 0; vld_cnt1 = 0; wr_cnt0 = 0; wr_cnt1 = 0;
        start = 1'b1;
    endtask

    task automatic load_vec(input int k);
        cur_f0 = vecs[k].f0; cur_f1 = vecs[k].f1;
        cur_rej0 = vecs[k].rej0; cur_rej1 = vecs[k].rej1;
    endtask

    task automatic run_vec(input int k);
        int  cyc;
        bit  got;
        string n;
        n = vecs[k].name;
        load_vec(k);
        build_model();
        mon_en = 1'b1; sb_en = 1'b1;
        start_frame();
        cyc = 0; got = 1'b0;
        while (!got && cyc < 400) begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (done) got = 1'b1;
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL %s_done_timeout: actual=none expected=%0d", n, vecs[k].exp_done);
        end else begin
            check({n, "_done_cycle"}, 32'(cyc), 32'(vecs[k].exp_done));
        end
        repeat (3) @(negedge clk);
        check({n, "_buffer_we_pulses"}, 32'(bw_cnt), 32'(ROWS));
        check({n, "_done_pulses"}, 32'(done_cnt), 32'd1);
        check({n, "_vld_ch0"}, 32'(vld_cnt0), 32'(mdl_vld0));
        check({n, "_vld_ch1"}, 32'(vld_cnt1), 32'(mdl_vld1));
        check({n, "_count_ch0"}, 32'(kp_count[KAW:0]), 32'(vecs[k].exp_cnt0));
        check({n, "_count_ch1"}, 32'(kp_count[2*KAW+1:KAW+1]), 32'(vecs[k].exp_cnt1));
        check({n, "_ovf_ch0"}, 32'(kp_overflow[0]), 32'(vecs[k].exp_ovf0));
        check({n, "_ovf_ch1"}, 32'(kp_overflow[1]), 32'(vecs[k].exp_ovf1));
        check({n, "_pending_ch0"}, 32'(exp_q0.size()), 32'd0);
        check({n, "_pending_ch1"}, 32'(exp_q1.size()), 32'd0);
        check({n, "_idle_after"}, 32'(busy), 32'd0);
        sb_en = 1'b0;
    endtask

    // ---------------- main sequence
    initial begin
        int n, cyc, dcnt, dcyc, maxp, p0, p1;
        logic b24, b25;

        for (int k = 0; k < 5; k++) begin
            vecs[k].f0 = '0; vecs[k].f1 = '0; vecs[k].rej0 = '0; vecs[k].rej1 = '0;
            vecs[k].exp_ovf0 = 1'b0; vecs[k].exp_ovf1 = 1'b0;
        end
        vecs[0].name = "all_zero";    vecs[0].exp_cnt0 = 0; vecs[0].exp_cnt1 = 0; vecs[0].exp_done = 23;
        vecs[1].name = "row3_basic";  vecs[1].f0[3] = 16'h8211; vecs[1].f1[3] = 16'h0004;
        vecs[1].exp_cnt0 = 2; vecs[1].exp_cnt1 = 1; vecs[1].exp_done = 24;
        vecs[2].name = "row3_reject"; vecs[2].f0[3] = 16'h8211; vecs[2].f1[3] = 16'h0004;
        vecs[2].rej0 = 16'h0010; vecs[2].exp_cnt0 = 1; vecs[2].exp_cnt1 = 1; vecs[2].exp_done = 24;
        vecs[3].name = "random";
        for (int r = 0; r < ROWS; r++) begin
            vecs[3].f0[r] = 16'($urandom_range(0, 16'hFFFF)) & 16'($urandom_range(0, 16'hFFFF));
            vecs[3].f1[r] = 16'($urandom_range(0, 16'hFFFF)) & 16'($urandom_range(0, 16'hFFFF));
        end
        vecs[3].rej0 = 16'($urandom_range(0, 16'hFFFF));
        vecs[3].rej1 = 16'($urandom_range(0, 16'hFFFF));
        load_vec(3);
        build_model();
        vecs[3].exp_cnt0 = mdl_cnt0; vecs[3].exp_cnt1 = mdl_cnt1;
        vecs[3].exp_ovf0 = mdl_ovf0; vecs[3].exp_ovf1 = mdl_ovf1;
        vecs[3].exp_done = 1;
        for (int r = 0; r < ROWS; r++) begin
            if (r < 2) vecs[3].exp_done += SRAM_LAT + 1;
            else begin
                p0 = $countones(vecs[3].f0[r] & 16'h7FFE);
                p1 = $countones(vecs[3].f1[r] & 16'h7FFE);
                maxp = (p0 > p1) ? p0 : p1;
                if (maxp < 1) maxp = 1;
                vecs[3].exp_done += SRAM_LAT + maxp + 1;
            end
        end
        vecs[4].name = "ch0_overflow";
        for (int r = 0; r < ROWS; r++) vecs[4].f0[r] = 16'h7FFE;
        vecs[4].f1[4] = 16'h0020;
        vecs[4].exp_cnt0 = 8; vecs[4].exp_cnt1 = 1; vecs[4].exp_ovf0 = 1'b1; vecs[4].exp_done = 75;

        cur_f0 = '0; cur_f1 = '0; cur_rej0 = '0; cur_rej1 = '0;

        // reset state
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_done", 32'(done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_buffer_we", 32'(buffer_we), 32'd0);
        check("rst_row_addr", 32'(row_addr), 32'd0);
        check("rst_cand_vld", 32'(cand_vld), 32'd0);
        check("rst_kp_we", 32'(kp_we), 32'd0);
        check("rst_kp_count", 32'(kp_count), 32'd0);
        check("rst_kp_overflow", 32'(kp_overflow), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int k = 0; k < 5; k++) run_vec(k);

        // overflow holds in IDLE, then a new start clears counts and overflow
        mon_en = 1'b0;
        check("ovf_hold_idle", 32'(kp_overflow[0]), 32'd1);
        cur_f0 = '0; cur_f1 = '0; cur_rej0 = '0; cur_rej1 = '0;
        start_frame();
        @(negedge clk);
        start = 1'b0;
        check("restart_clears_count", 32'(kp_count), 32'd0);
        check("restart_clears_ovf", 32'(kp_overflow), 32'd0);
        check("restart_busy", 32'(busy), 32'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_fetch_idle", 32'(busy), 32'd0);

        // abort during SCAN on the third ch0 candidate
        load_vec(4);
        cur_f1 = '0;
        mon_en = 1'b1; sb_en = 1'b0;
        start_frame();
        n = 0; cyc = 0;
        while (n < 3 && cyc < 200) begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (cand_vld[0]) n++;
        end
        if (n < 3) begin
            checks++; errors++;
            $display("FAIL abort_wait_scan: actual=%0d expected=3", n);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_no_done", 32'(done), 32'd0);
        check("abort_cand_vld", 32'(cand_vld), 32'd0);
        repeat (20) @(negedge clk);
        check("abort_writes_ch0", 32'(wr_cnt0), 32'd2);
        check("abort_done_pulses", 32'(done_cnt), 32'd0);
        check("abort_count_hold", 32'(kp_count[KAW:0]), 32'd2);
        check("abort_still_idle", 32'(busy), 32'd0);
        mon_en = 1'b0;

        // start held high through DONE
        cur_f0 = '0; cur_f1 = '0;
        @(negedge clk);
        start = 1'b1;
        dcnt = 0; dcyc = 0; b24 = 1'b1; b25 = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (done) begin
                if (dcnt == 0) dcyc = c;
                dcnt++;
            end
            if (c == 24) b24 = busy;
            if (c == 25) b25 = busy;
        end
        start = 1'b0;
        check("hold_done_pulses", 32'(dcnt), 32'd1);
        check("hold_done_cycle", 32'(dcyc), 32'd23);
        check("hold_idle_reentered", 32'(b24), 32'd0);
        check("hold_restart", 32'(b25), 32'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("hold_abort_idle", 32'(busy), 32'd0);

        // abort beats start in IDLE
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("abort_prio_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("abort_prio_state", 32'(dbg_state), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/keypoint_scan_ctrl.md
Name: keypoint_scan_ctrl

Overview:
- Parametrised row-sequencing controller for the DoG keypoint stage.
- Steps the scale-space SRAMs through the image row by row and drives the line-buffer write strobe.
- Serialises each row's per-column candidate flags from NCH external detector instances into one candidate per channel per cycle, queried against external filter logic.
- Writes passing keypoints as {row, col} into NCH keypoint SRAMs, with saturating capacity, overflow flags and abort.

Parameters:
NCH, 2, number of detector/filter/keypoint-SRAM channels
COLS, 640, pixels per row (candidate-flag width per channel)
ROWS, 480, image rows
RAW, 9, row address width
CAW, 10, column index width
KAW, 11, keypoint SRAM address width
SRAM_LAT, 2, cycles from row_addr change to valid SRAM dout (>=1)

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
start  in  1  begin frame; honoured only in IDLE
abort  in  1  synchronous abort to IDLE
done  out  1  one-cycle pulse, frame complete
busy  out  1  high whenever state != IDLE
row_addr  out  RAW  row address to all scale SRAMs
buffer_we  out  1  line-buffer shift strobe
cand_flags  in  NCH*COLS  detector outputs; bit ch*COLS+c = candidate at column c
cand_vld  out  NCH  channel ch presents a candidate this cycle
cand_col  out  NCH*CAW  candidate column per channel
filt_pass  in  NCH  filter verdict for cand_col, combinational, same cycle
kp_we  out  NCH  keypoint SRAM write enable
kp_addr  out  NCH*KAW  keypoint SRAM address
kp_din  out  NCH*(RAW+CAW)  {center_row, col}
kp_count  out  NCH*(KAW+1)  keypoints written this frame
kp_overflow  out  NCH  sticky: a passing keypoint was dropped because the SRAM was full

Behaviour:
Reset (rst_n=0 at posedge):
- state=IDLE.
- All outputs 0; masks, counters and overflow cleared.

States:
- IDLE: if start, go to FETCH; clear kp_addr, kp_count, kp_overflow and row_addr.
- FETCH: hold row_addr for SRAM_LAT cycles (lat counter). Then:
  - if row_addr>=2: latch masks and go to SCAN;
  - else go to ADVANCE.
- SCAN:
  - Each channel independently takes the lowest set bit p of its mask.
  - cand_vld[ch]=1, cand_col[ch]=p; that bit is cleared at the clock edge.
  - If filt_pass[ch]&&cand_vld[ch] is sampled, a write is issued next cycle.
  - When all masks are zero, go to ADVANCE. SCAN always lasts at least 1 cycle, i.e. max popcount over channels (min 1).
- ADVANCE:
  - buffer_we=1 for exactly this cycle; SRAM dout is still valid for the current row.
  - If row_addr==ROWS-1, go to DONE; else row_addr+1 and go to FETCH.
- DONE: done=1 for one cycle, then IDLE.

Mask latch:
- mask[ch] = cand_flags slice with bits 0 and COLS-1 forced to 0 (border columns never reported).

Centre row and write path:
- Centre row of a scan = row_addr-1. Rows 0 and ROWS-1 are never reported.
- Write is registered: kp_we[ch]=1 the cycle after the pass, with kp_din = {row_addr-1, col}.
- kp_addr increments after each write; kp_count = number of writes.
- Channels are fully independent; simultaneous writes on all channels are legal.

Full condition:
- After a write at kp_addr=2^KAW-1, channel ch is full: kp_addr stays, kp_count = 2^KAW.
- Further passes on that channel are dropped (no kp_we) and set kp_overflow[ch].
- Scanning continues, so the other channels are unaffected.

Control corner cases:
- abort in any non-IDLE state → IDLE next cycle; no done; pending write suppressed; kp_count/kp_overflow hold until the next start.
- abort has priority over start.
- start outside IDLE is ignored.
- buffer_we is never asserted outside ADVANCE.

Test Plan:
- Common setup: NCH=2, COLS=16, ROWS=6, KAW=3, SRAM_LAT=2, all flags 0.
- All flags 0; start at cycle 0 → row_addr steps 0..5; 6 buffer_we pulses; cand_vld never asserted; done pulses at cycle 23; kp_count=0.
- Row 3 fetched; ch0 flags bits {0,4,9,15}, ch1 bit {2}; filt_pass=1 → ch0 cand_col 4 then 9 (two SCAN cycles), ch1 cand_col 2; writes din {2,4},{2,9} on ch0 and {2,2} on ch1.
- Same row, filt_pass[0]=0 on col 4 → only {2,9} written on ch0, at kp_addr 0.
- ch0 flags all interior bits set on every row, filt_pass=1 → exactly 8 writes (addr 0..7); kp_count[0]=8; kp_overflow[0]=1; ch1 unaffected and done still pulses.
- abort asserted during SCAN → IDLE next cycle, busy=0, no done, no further kp_we; a new start clears counts and overflow.
- start held high through DONE → frame does not restart until IDLE is re-entered; exactly one done pulse per frame.
